// File: rtl/pipeline_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_pkg
// Shared definitions for the 5-stage MIPS pipeline front end.
//   - XLEN                : instruction / address width (32)
//   - DEFAULT_RESET_PC    : PC loaded on reset unless overridden
//   - DEFAULT_NOP_INSTR   : instruction word used for bubbles and reset
//   - fetch_state_t       : fetch-stage FSM states (IDLE, FETCH, HOLD)
//   - align_word()        : forces an address onto a 4-byte boundary
// -----------------------------------------------------------------------------
package pipeline_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [XLEN-1:0] DEFAULT_RESET_PC  = 32'h0000_0000;
   localparam logic [XLEN-1:0] DEFAULT_NOP_INSTR = 32'h0000_0000;

   localparam logic [XLEN-1:0] PC_STEP = 32'd4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2
   } fetch_state_t;

   // Instructions are word aligned; the two low address bits are dropped.
   function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
      return {addr[XLEN-1:2], 2'b00};
   endfunction

endpackage : pipeline_pkg

// File: rtl/if_id_reg.sv
// -----------------------------------------------------------------------------
// if_id_reg
// IF/ID pipeline register with write-enable and flush.
//   clk          in   clock, rising edge
//   rst_n        in   synchronous active-low reset (loads a bubble)
//   write_en     in   load instr_in / pc_plus4_in as a valid instruction
//   flush        in   load a bubble {NOP_INSTR, 0, valid=0}; beats write_en
//   instr_in     in   instruction word to capture
//   pc_plus4_in  in   PC+4 of that instruction
//   instruction  out  registered instruction
//   pc_plus4     out  registered PC+4
//   valid        out  1 when a real instruction is held
// -----------------------------------------------------------------------------
module if_id_reg
   import pipeline_pkg::*;
#(
   parameter logic [XLEN-1:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            write_en,
   input  logic            flush,
   input  logic [XLEN-1:0] instr_in,
   input  logic [XLEN-1:0] pc_plus4_in,
   output logic [XLEN-1:0] instruction,
   output logic [XLEN-1:0] pc_plus4,
   output logic            valid
);

   logic [XLEN-1:0] instr_reg;
   logic [XLEN-1:0] pc_plus4_reg;
   logic            valid_reg;

   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         instr_reg    <= NOP_INSTR;
         pc_plus4_reg <= '0;
         valid_reg    <= 1'b0;
      end else if (write_en) begin
         instr_reg    <= instr_in;
         pc_plus4_reg <= pc_plus4_in;
         valid_reg    <= 1'b1;
      end
   end

   assign instruction = instr_reg;
   assign pc_plus4    = pc_plus4_reg;
   assign valid       = valid_reg;

endmodule : if_id_reg

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage: PC register, next-PC selection, instruction-memory
// request and the IF/ID pipeline register.
//   clk               in   clock, rising edge
//   rst_n             in   synchronous active-low reset
//   PCWrite           in   hazard unit: 0 holds the PC
//   IF_ID_Write       in   hazard unit: 0 holds IF/ID
//   PCSrc             in   taken-branch redirect (priority over Jump)
//   branch_target     in   branch destination
//   Jump              in   jump redirect
//   jump_target       in   jump destination
//   imem_req          out  fetch request (1 only in FETCH)
//   imem_addr         out  fetch address (the PC register)
//   imem_data         in   instruction word
//   imem_ready        in   imem_data valid for the imem_addr of this cycle
//   IF_ID_Instruction out  registered instruction to decode
//   IF_ID_PC_plus4    out  registered PC+4 of that instruction
//   IF_ID_Valid       out  1 when IF/ID holds a real instruction
// -----------------------------------------------------------------------------
module fetch_stage
   import pipeline_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC  = DEFAULT_RESET_PC,
   parameter logic [XLEN-1:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            PCWrite,
   input  logic            IF_ID_Write,
   input  logic            PCSrc,
   input  logic [XLEN-1:0] branch_target,
   input  logic            Jump,
   input  logic [XLEN-1:0] jump_target,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic [XLEN-1:0] imem_data,
   input  logic            imem_ready,
   output logic [XLEN-1:0] IF_ID_Instruction,
   output logic [XLEN-1:0] IF_ID_PC_plus4,
   output logic            IF_ID_Valid
);

   fetch_state_t    state_reg;
   logic [XLEN-1:0] pc_reg;
   logic            req_reg;
   logic [XLEN-1:0] buf_instr_reg;
   logic [XLEN-1:0] buf_pc4_reg;

   logic            stall;
   logic            redirect;
   logic [XLEN-1:0] pc_plus4;
   logic [XLEN-1:0] redirect_target;

   logic            ifid_we;
   logic            ifid_flush;
   logic [XLEN-1:0] ifid_instr_next;
   logic [XLEN-1:0] ifid_pc4_next;

   // Either hazard control being low stalls the whole fetch step, so PC and
   // IF/ID always advance together.
   assign stall    = !(PCWrite && IF_ID_Write);
   assign redirect = PCSrc || Jump;
   assign pc_plus4 = pc_reg + PC_STEP;   // wraps modulo 2^32

   assign redirect_target = PCSrc ? align_word(branch_target)
                                  : align_word(jump_target);

   // ---------------------------------------------------------------------
   // FSM, PC and holding buffer. imem_req is registered alongside the state
   // so it is high exactly while the FSM sits in FETCH.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         pc_reg        <= RESET_PC;
         req_reg       <= 1'b0;
         buf_instr_reg <= NOP_INSTR;
         buf_pc4_reg   <= '0;
      end else if (redirect) begin
         // A redirect beats stalls and in-flight data: any buffered word
         // belongs to the wrong path and memory restarts on the target.
         state_reg     <= FETCH;
         pc_reg        <= redirect_target;
         req_reg       <= 1'b1;
         buf_instr_reg <= NOP_INSTR;
         buf_pc4_reg   <= '0;
      end else begin
         unique case (state_reg)
            IDLE: begin
               state_reg <= FETCH;
               req_reg   <= 1'b1;
            end

            FETCH: begin
               if (imem_ready) begin
                  if (!stall) begin
                     pc_reg <= pc_plus4;
                  end else begin
                     // Memory has already answered; park the word so the
                     // request can be dropped while decode is stalled.
                     buf_instr_reg <= imem_data;
                     buf_pc4_reg   <= pc_plus4;
                     state_reg     <= HOLD;
                     req_reg       <= 1'b0;
                  end
               end
            end

            HOLD: begin
               if (!stall) begin
                  pc_reg    <= pc_plus4;
                  state_reg <= FETCH;
                  req_reg   <= 1'b1;
               end
            end

            default: begin
               state_reg <= IDLE;
               req_reg   <= 1'b0;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // IF/ID load selection.
   // ---------------------------------------------------------------------
   always_comb begin
      ifid_we         = 1'b0;
      ifid_flush      = redirect;
      ifid_instr_next = imem_data;
      ifid_pc4_next   = pc_plus4;

      if (!redirect) begin
         unique case (state_reg)
            FETCH: begin
               if (imem_ready && !stall) begin
                  ifid_we = 1'b1;
               end else if (!imem_ready && IF_ID_Write) begin
                  // Waiting on memory: let decode see a bubble rather than
                  // re-issuing the previous instruction.
                  ifid_flush = 1'b1;
               end
            end

            HOLD: begin
               if (!stall) begin
                  ifid_we         = 1'b1;
                  ifid_instr_next = buf_instr_reg;
                  ifid_pc4_next   = buf_pc4_reg;
               end
            end

            default: begin
               ifid_we = 1'b0;
            end
         endcase
      end
   end

   if_id_reg #(
      .NOP_INSTR (NOP_INSTR)
   ) u_if_id_reg (
      .clk         (clk),
      .rst_n       (rst_n),
      .write_en    (ifid_we),
      .flush       (ifid_flush),
      .instr_in    (ifid_instr_next),
      .pc_plus4_in (ifid_pc4_next),
      .instruction (IF_ID_Instruction),
      .pc_plus4    (IF_ID_PC_plus4),
      .valid       (IF_ID_Valid)
   );

   assign imem_req  = req_reg;
   assign imem_addr = pc_reg;

endmodule : fetch_stage

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
// Scoreboard bench for fetch_stage. A stimulus process drives the inputs on
// the falling edge, advances a behavioural model of the fetch rules and pushes
// the expected post-edge outputs; a monitor pops and compares after each
// rising edge.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam logic [31:0] NOP    = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        PCWrite = 1'b1;
   logic        IF_ID_Write = 1'b1;
   logic        PCSrc = 1'b0;
   logic [31:0] branch_target = '0;
   logic        Jump = 1'b0;
   logic [31:0] jump_target = '0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_data = '0;
   logic        imem_ready = 1'b0;
   logic [31:0] IF_ID_Instruction;
   logic [31:0] IF_ID_PC_plus4;
   logic        IF_ID_Valid;

   always #5 clk = ~clk;

   fetch_stage #(
      .RESET_PC  (RST_PC),
      .NOP_INSTR (NOP)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .PCWrite           (PCWrite),
      .IF_ID_Write       (IF_ID_Write),
      .PCSrc             (PCSrc),
      .branch_target     (branch_target),
      .Jump              (Jump),
      .jump_target       (jump_target),
      .imem_req          (imem_req),
      .imem_addr         (imem_addr),
      .imem_data         (imem_data),
      .imem_ready        (imem_ready),
      .IF_ID_Instruction (IF_ID_Instruction),
      .IF_ID_PC_plus4    (IF_ID_PC_plus4),
      .IF_ID_Valid       (IF_ID_Valid)
   );

   // Instruction memory contents: word n holds 0x2000_0000 + (n+1)*0x0001_0001,
   // so addresses 0,4,8 hold 0x2001_0001, 0x2002_0002, 0x2003_0003.
   function automatic logic [31:0] mem_word(input logic [31:0] addr);
      return 32'h2000_0000 + ((addr >> 2) + 32'd1) * 32'h0001_0001;
   endfunction

   typedef struct {
      logic        req;
      logic [31:0] addr;
      logic [31:0] instr;
      logic [31:0] pc4;
      logic        valid;
      logic        loaded;
   } exp_t;

   exp_t exp_q[$];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // ---------------- behavioural model ----------------
   // phase: 0 = waiting to start after reset, 1 = requesting, 2 = parked word
   int          m_phase = 0;
   logic [31:0] m_pc = RST_PC;
   logic [31:0] m_parked[$];
   logic [31:0] m_instr = NOP;
   logic [31:0] m_pc4 = '0;
   logic        m_valid = 1'b0;

   task automatic model_edge(input logic r, input logic pcw, input logic ifw,
                             input logic ps, input logic [31:0] bt,
                             input logic jp, input logic [31:0] jt,
                             input logic rdy, output logic loaded);
      logic stalled;
      stalled = !(pcw && ifw);
      loaded  = 1'b0;
      if (!r) begin
         m_phase = 0; m_pc = RST_PC; m_parked.delete();
         m_instr = NOP; m_pc4 = 0; m_valid = 0;
      end else if (ps || jp) begin
         m_pc = ps ? (bt & ~32'd3) : (jt & ~32'd3);
         m_parked.delete();
         m_instr = NOP; m_pc4 = 0; m_valid = 0;
         m_phase = 1;
      end else if (m_phase == 0) begin
         m_phase = 1;
      end else if (m_phase == 1) begin
         if (rdy && !stalled) begin
            m_instr = mem_word(m_pc); m_pc4 = m_pc + 4; m_valid = 1;
            m_pc = m_pc + 4; loaded = 1'b1;
         end else if (rdy) begin
            m_parked.push_back(mem_word(m_pc));
            m_phase = 2;
         end else if (ifw) begin
            m_instr = NOP; m_pc4 = 0; m_valid = 0;
         end
      end else begin
         if (!stalled) begin
            m_instr = m_parked.pop_front(); m_pc4 = m_pc + 4; m_valid = 1;
            m_pc = m_pc + 4; m_phase = 1; loaded = 1'b1;
         end
      end
   endtask

   // One clock of stimulus: drive, update model, push expectation.
   task automatic step(input logic r, input logic pcw, input logic ifw,
                       input logic ps, input logic [31:0] bt,
                       input logic jp, input logic [31:0] jt, input logic rdy);
      exp_t e;
      logic ld;
      @(negedge clk);
      rst_n = r; PCWrite = pcw; IF_ID_Write = ifw;
      PCSrc = ps; branch_target = bt; Jump = jp; jump_target = jt;
      imem_ready = rdy;
      imem_data  = rdy ? mem_word(imem_addr) : 32'hDEAD_BEEF;
      model_edge(r, pcw, ifw, ps, bt, jp, jt, rdy, ld);
      e.req    = (m_phase == 1);
      e.addr   = m_pc;
      e.instr  = m_instr;
      e.pc4    = m_pc4;
      e.valid  = m_valid;
      e.loaded = ld;
      exp_q.push_back(e);
   endtask

   task automatic go(input logic rdy);
      step(1, 1, 1, 0, 0, 0, 0, rdy);
   endtask

   task automatic hold_stall(input logic rdy);
      step(1, 0, 0, 0, 0, 0, 0, rdy);
   endtask

   // ---------------- monitor ----------------
   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
      end
   endtask

   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() != 0) begin
            cyc++;
            e = exp_q.pop_front();
            chk("imem_req",  {31'd0, imem_req},    {31'd0, e.req});
            chk("imem_addr", imem_addr,            e.addr);
            chk("instr",     IF_ID_Instruction,    e.instr);
            chk("pc_plus4",  IF_ID_PC_plus4,       e.pc4);
            chk("valid",     {31'd0, IF_ID_Valid}, {31'd0, e.valid});
            if (e.loaded)
               $display("cyc=%0d fetched instr=%h pc_plus4=%h next_addr=%h",
                        cyc, IF_ID_Instruction, IF_ID_PC_plus4, imem_addr);
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      // reset for two cycles, with noise on the other inputs
      step(0, 1, 1, 1, 32'h44, 0, 0, 1);
      step(0, 0, 1, 0, 0, 1, 32'h88, 1);
      // release: first request at RESET_PC
      go(1);
      // zero-wait stream: addresses 0 and 4
      go(1);
      go(1);
      // stall two cycles at PC=8 with memory answering
      hold_stall(1);
      hold_stall(1);
      go(1);              // word from 8 enters, next address 12
      go(1);              // fetch 12 -> PC = 0x10
      // three wait states at 0x10, then the instruction
      go(0); go(0); go(0);
      go(1);
      // park the word at 0x14, then branch away while holding
      hold_stall(1);
      step(1, 0, 0, 1, 32'h40, 0, 0, 1);
      go(1);
      // simultaneous branch and jump: branch wins, target aligned
      step(1, 1, 1, 1, 32'h83, 1, 32'h100, 1);
      go(1);
      // top-of-memory wrap
      step(1, 1, 1, 0, 0, 1, 32'hFFFF_FFFF, 1);
      go(1);
      go(1);
      // reset while a word is parked
      hold_stall(1);
      step(0, 0, 0, 0, 0, 0, 0, 1);
      go(1);
      go(1);
      // randomized traffic
      for (int i = 0; i < 1500; i++) begin
         logic [31:0] bt, jt;
         bt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
         jt = ($urandom_range(0, 3) == 0) ? ($urandom & 32'hFF) : $urandom;
         step(($urandom_range(0, 99) != 0),
              ($urandom_range(0, 7) != 0),
              ($urandom_range(0, 7) != 0),
              ($urandom_range(0, 19) == 0), bt,
              ($urandom_range(0, 19) == 0), jt,
              ($urandom_range(0, 3) != 0));
      end
      @(posedge clk);
      #2;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain pending=%0d want=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_fetch_stage

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 5-stage MIPS pipeline: owns the PC register, next-PC selection, the instruction-memory request, and the IF/ID pipeline register. It consumes the hazard unit's `PCWrite` and `IF_ID_Write` stall controls and the branch/jump redirects from later stages. It delivers one instruction per cycle to decode when memory has zero wait states.

## Interface

Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `NOP_INSTR`, default 32'h0000_0000: instruction word used for bubbles and for reset.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `PCWrite` input 1: from the hazard unit; 0 means hold the PC.
- `IF_ID_Write` input 1: from the hazard unit; 0 means hold IF/ID.
- `PCSrc` input 1: taken-branch redirect.
- `branch_target` input 32: branch destination.
- `Jump` input 1: jump redirect.
- `jump_target` input 32: jump destination.
- `imem_req` output 1: fetch request.
- `imem_addr` output 32: fetch address; equals the PC register.
- `imem_data` input 32: instruction word.
- `imem_ready` input 1: qualifies `imem_data` for the `imem_addr` presented in the same cycle.
- `IF_ID_Instruction` output 32: registered instruction to decode.
- `IF_ID_PC_plus4` output 32: registered PC+4 of that instruction.
- `IF_ID_Valid` output 1: 1 when IF/ID holds a real instruction.

## Operation

- Stall is defined as `!(PCWrite & IF_ID_Write)`. Redirect is defined as `PCSrc | Jump`.
- Registered FSM with states IDLE, FETCH and HOLD. `imem_req` = 1 only in FETCH.
- IDLE: entered on reset. Moves to FETCH unconditionally on the next cycle.
- FETCH, `imem_ready`=1, no stall: IF/ID ← {`imem_data`, PC+4, valid=1}; PC ← PC+4.
- FETCH, `imem_ready`=1, stall: buffer ← {`imem_data`, PC+4}; PC and IF/ID held; go to HOLD.
- FETCH, `imem_ready`=0: PC held. If `IF_ID_Write`=1, IF/ID ← bubble ({`NOP_INSTR`, 0, valid=0}). Otherwise IF/ID is held.
- HOLD, stall still active: everything held.
- HOLD, stall released: IF/ID ← buffer with valid=1; PC ← PC+4; go to FETCH.
- Redirect in any state overrides the stall and wins over all other events:
  - PC ← target, with `PCSrc` taking priority over `Jump`.
  - IF/ID ← bubble.
  - Buffer discarded.
  - Next state is FETCH (IDLE still goes to FETCH).
- Redirect targets have bits [1:0] forced to 00.
- PC arithmetic wraps modulo 2^32: 32'hFFFF_FFFC + 4 = 0.

## Timing

- Reset values: PC = `RESET_PC`, `imem_req` = 0, `IF_ID_Instruction` = `NOP_INSTR`, `IF_ID_PC_plus4` = 0, `IF_ID_Valid` = 0, state IDLE, buffer cleared.
- If reset is asserted mid-operation, all of the above hold at the next edge, including a discard of any in-flight data.
- First request: `imem_req` = 1 with `imem_addr` = `RESET_PC` in the first cycle after `rst_n` rises.
- Latency is 1 cycle from `imem_ready` to the IF/ID outputs. Throughput is 1 instruction/cycle with zero-wait memory.
- `imem_addr` stays stable while `imem_req`=1 and `imem_ready`=0, unless a redirect occurs. On a redirect the address changes at the next edge, and memory must restart on the new address.
- Redirect effect: the target appears on `imem_addr` and `IF_ID_Valid` = 0 in the cycle after the redirect.
- The hazard-unit inputs are combinational and are sampled only at the clock edge.

## Structure

- Shared package `pipeline_pkg` holds:
  - fetch-state enum (IDLE, FETCH, HOLD);
  - `NOP_INSTR` default;
  - `RESET_PC` default;
  - instruction/address width constant (32).
- Sub-module `if_id_reg` implements the IF/ID register with write-enable, flush (bubble) and synchronous active-low reset.
- `fetch_stage` holds the PC, FSM, buffer and next-PC mux.

## Test plan

- Reset: hold `rst_n`=0 for 2 cycles → PC=0, `imem_req`=0, `IF_ID_Valid`=0. Release → next cycle `imem_req`=1, `imem_addr`=0.
- Zero-wait stream: `imem_ready`=1, data 0x2001_0001, 0x2002_0002, 0x2003_0003 → IF/ID shows each word one cycle later, with `IF_ID_PC_plus4` = 4, 8, 12.
- Stall:
  - Stimulus: at PC=8 with `imem_ready`=1, drive `PCWrite`=`IF_ID_Write`=0 for 2 cycles.
  - Response: IF/ID held, `imem_req`=0 in HOLD.
  - On release: word from address 8 enters IF/ID with PC+4=12, and `imem_addr`=12.
- Wait states: `imem_ready`=0 for 3 cycles at PC=0x10 → `imem_addr` stays at 0x10, 3 bubbles with `IF_ID_Valid`=0, then the instruction enters.
- Redirect during HOLD: `PCSrc`=1, `branch_target`=0x40 → buffer dropped, `IF_ID_Valid`=0, next `imem_addr`=0x40, FSM in FETCH.
- Priority and alignment: `PCSrc`=`Jump`=1 with targets 0x83/0x100 → `imem_addr`=0x80. Separately, PC=0xFFFF_FFFC fetched → next `imem_addr`=0.
